// File: rtl/raster_iter_pkg.sv
// Shared types and helpers for the raster sample iterator.
//   iter_state_t   : iterator FSM states
//   SS_*           : one-hot sub-sample rate codes
//   step_from_rate : grid step (fixed point) for a sub-sample rate code
package raster_iter_pkg;

  localparam int unsigned SIGFIG = 24;  // bits in colour and position
  localparam int unsigned RADIX  = 10;  // fraction bits
  localparam int unsigned VERTS  = 3;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;

  typedef enum logic {
    WAIT,
    TEST
  } iter_state_t;

  localparam logic [3:0] SS_1X  = 4'b1000;
  localparam logic [3:0] SS_4X  = 4'b0100;
  localparam logic [3:0] SS_16X = 4'b0010;
  localparam logic [3:0] SS_64X = 4'b0001;

  // Non-one-hot codes fall back to one sample per pixel.
  function automatic logic signed [SIGFIG-1:0] step_from_rate(input logic [3:0] rate);
    logic signed [SIGFIG-1:0] step;
    step = '0;
    case (rate)
      SS_4X:   step[RADIX-1] = 1'b1;
      SS_16X:  step[RADIX-2] = 1'b1;
      SS_64X:  step[RADIX-3] = 1'b1;
      default: step[RADIX]   = 1'b1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/iter_step.sv
// Combinational raster-order advance of the sample cursor.
//   cur_x_i/cur_y_i : current sample
//   ll_x_i          : box left edge (row wrap target)
//   ur_x_i/ur_y_i   : box upper-right corner
//   step_i          : grid step
//   nxt_x_o/nxt_y_o : next sample (valid when done_o is low)
//   done_o          : current sample was the last one in the box
module iter_step
  import raster_iter_pkg::*;
(
  input  logic signed [SIGFIG-1:0] cur_x_i,
  input  logic signed [SIGFIG-1:0] cur_y_i,
  input  logic signed [SIGFIG-1:0] ll_x_i,
  input  logic signed [SIGFIG-1:0] ur_x_i,
  input  logic signed [SIGFIG-1:0] ur_y_i,
  input  logic signed [SIGFIG-1:0] step_i,
  output logic signed [SIGFIG-1:0] nxt_x_o,
  output logic signed [SIGFIG-1:0] nxt_y_o,
  output logic                     done_o
);

  // One guard bit so stepping past a box edge near full scale cannot wrap negative.
  logic signed [SIGFIG:0] nx, ny, ux, uy;

  assign nx = $signed({cur_x_i[SIGFIG-1], cur_x_i}) + $signed({step_i[SIGFIG-1], step_i});
  assign ny = $signed({cur_y_i[SIGFIG-1], cur_y_i}) + $signed({step_i[SIGFIG-1], step_i});
  assign ux = $signed({ur_x_i[SIGFIG-1], ur_x_i});
  assign uy = $signed({ur_y_i[SIGFIG-1], ur_y_i});

  always_comb begin
    nxt_x_o = cur_x_i;
    nxt_y_o = cur_y_i;
    done_o  = 1'b0;
    if (nx <= ux) begin
      nxt_x_o = nx[SIGFIG-1:0];
    end else if (ny <= uy) begin
      nxt_x_o = ll_x_i;
      nxt_y_o = ny[SIGFIG-1:0];
    end else begin
      done_o = 1'b1;
    end
  end

endmodule

// File: rtl/sample_iterator.sv
// Walks every sub-sample grid point of a triangle's bounding box in raster
// order (x fastest, bottom row first), one sample per cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   tri_R14S          : triangle from bounding-box stage
//   color_R14U        : triangle colour
//   box_R14S          : [0]=lower-left (x,y), [1]=upper-right (x,y)
//   validTri_R14H     : triangle and box valid
//   subSample_RnnnnU  : one-hot sub-sample rate
//   halt_RnnnnH       : upstream must hold (iterating)
//   tri_R15S          : latched triangle
//   color_R15U        : latched colour
//   sample_R15S       : current sample [0]=x, [1]=y
//   validSamp_R15H    : sample_R15S valid
module sample_iterator
  import raster_iter_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R14S,
  input  logic                                         validTri_R14H,
  input  logic        [3:0]                            subSample_RnnnnU,
  output logic                                         halt_RnnnnH,
  output logic        [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R15S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R15U,
  output logic signed [1:0][SIGFIG-1:0]                 sample_R15S,
  output logic                                         validSamp_R15H
);

  iter_state_t state_q, state_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
  logic signed [SIGFIG-1:0] ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
  logic signed [SIGFIG-1:0] step_q, step_d, x_q, x_d, y_q, y_d;
  logic                     valid_q, valid_d;

  logic signed [SIGFIG-1:0] nxt_x, nxt_y;
  logic                     done;

  iter_step u_iter_step (
    .cur_x_i (x_q),
    .cur_y_i (y_q),
    .ll_x_i  (ll_x_q),
    .ur_x_i  (ur_x_q),
    .ur_y_i  (ur_y_q),
    .step_i  (step_q),
    .nxt_x_o (nxt_x),
    .nxt_y_o (nxt_y),
    .done_o  (done)
  );

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    color_d = color_q;
    ll_x_d  = ll_x_q;
    ur_x_d  = ur_x_q;
    ur_y_d  = ur_y_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    case (state_q)
      WAIT: begin
        valid_d = 1'b0;
        if (validTri_R14H) begin
          tri_d   = tri_R14S;
          color_d = color_R14U;
          ll_x_d  = box_R14S[0][0];
          ur_x_d  = box_R14S[1][0];
          ur_y_d  = box_R14S[1][1];
          step_d  = step_from_rate(subSample_RnnnnU);
          x_d     = box_R14S[0][0];
          y_d     = box_R14S[0][1];
          valid_d = 1'b1;
          state_d = TEST;
        end
      end
      TEST: begin
        // New triangles are ignored here; halt holds them upstream.
        if (done) begin
          valid_d = 1'b0;
          state_d = WAIT;
        end else begin
          x_d = nxt_x;
          y_d = nxt_y;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      tri_q   <= '0;
      color_q <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      ll_x_q  <= ll_x_d;
      ur_x_q  <= ur_x_d;
      ur_y_q  <= ur_y_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign halt_RnnnnH    = (state_q == TEST);
  assign tri_R15S       = tri_q;
  assign color_R15U     = color_q;
  assign sample_R15S[0] = x_q;
  assign sample_R15S[1] = y_q;
  assign validSamp_R15H = valid_q;

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
Raster stage directly upstream of the sample test, between bounding-box generation and the sample test. It accepts one triangle plus its bounding box, walks every sub-sample grid point inside the box in raster order, and emits one sample location per cycle with the triangle and colour alongside. While it is iterating it raises halt to stall the bounding-box stage.

Parameters:
SIGFIG, 24, bits in colour and position (signed fixed point)
RADIX, 10, fraction bits in colour and position
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, colour channels

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tri_R14S  in  VERTS x AXIS x SIGFIG signed  triangle from bounding-box stage
color_R14U  in  COLORS x SIGFIG  triangle colour
box_R14S  in  2 x 2 x SIGFIG signed  [0]=lower-left (x,y), [1]=upper-right (x,y)
validTri_R14H  in  1  triangle and box valid
subSample_RnnnnU  in  4  one-hot rate: 1000=1x, 0100=4x, 0010=16x, 0001=64x
halt_RnnnnH  out  1  high = upstream must hold; triangle not accepted
tri_R15S  out  VERTS x AXIS x SIGFIG  latched triangle
color_R15U  out  COLORS x SIGFIG  latched colour
sample_R15S  out  2 x SIGFIG signed  current sample (x,y)
validSamp_R15H  out  1  sample_R15S valid this cycle

Behaviour:
- Reset (async, rst=1): state WAIT; all outputs 0, including halt and validSamp. Asserting reset mid-triangle aborts iteration immediately; the remaining samples are dropped.
- Step: 1x uses 1<<RADIX, 4x uses 1<<(RADIX-1), 16x uses 1<<(RADIX-2), 64x uses 1<<(RADIX-3). Any non-one-hot code is treated as 1x. Rate is sampled only at triangle accept.
- Box corners are guaranteed by upstream to lie on the step grid, with ll <= ur on both axes.
- halt_RnnnnH = (state == TEST). It is a registered state decode, not combinational from inputs.
- WAIT state:
  - If validTri_R14H = 1, latch tri, colour, box and step.
  - Same edge: sample_R15S <= box ll corner, validSamp <= 1, state <= TEST.
  - Otherwise validSamp <= 0 and the outputs hold their values.
- TEST state, each cycle:
  - nx = x + step.
  - If nx <= ur.x (signed compare): x <= nx.
  - Else if y + step <= ur.y: x <= ll.x, y <= y + step.
  - Else (done): validSamp <= 0, state <= WAIT.
  - validTri_R14H is ignored in TEST.
- Latency: first sample appears 1 cycle after the accept edge.
- Sample count per triangle: ((ur.x-ll.x)/step+1) * ((ur.y-ll.y)/step+1).
- Order: x fastest, then y, bottom to top.
- Degenerate box (ll == ur): exactly one sample, then WAIT.
- Back-to-back triangles: after the last sample, one WAIT cycle with halt=0; the next triangle is accepted in that cycle. Minimum gap is 1 cycle with validSamp=0.
- Arithmetic: all adds and compares at SIGFIG+1 bits signed to avoid overflow at the box edge. Outputs are truncated back to SIGFIG.
- tri_R15S and color_R15U are stable for the whole TEST run.

Decomposition:
- Package raster_iter_pkg holds:
  - iter_state_t enum {WAIT, TEST}
  - one-hot rate constants SS_1X, SS_4X, SS_16X, SS_64X
  - function step_from_rate(rate) returning a SIGFIG-wide step
- One sub-module, iter_step: purely combinational. Takes cur (x,y), box and step; returns next (x,y) and done. Top level holds the FSM and registers.

Test Plan:
1. RADIX=10, 1x, box (0,0)-(2048,1024), validTri pulse.
   -> Samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles.
   -> halt high for those 6 cycles; validSamp low after.
2. Degenerate box (3072,3072)-(3072,3072), 1x.
   -> Exactly 1 sample (3072,3072), halt high for 1 cycle.
3. 4x (step 512), box (-512,-512)-(0,0).
   -> 4 samples (-512,-512),(0,-512),(-512,0),(0,0); negative coordinates handled.
4. validTri held high across two triangles (boxes of 2 and 1 samples).
   -> Samples 2, gap 1 cycle, then 1 sample.
   -> Second triangle latched only in the halt=0 cycle; tri_R15S switches exactly then.
5. Assert rst for 1 cycle during the 3rd sample of case 1.
   -> Outputs immediately 0, state WAIT; the next validTri restarts from ll.
6. Box ur.x = max positive grid value (e.g. (2^(SIGFIG-1)) - 1024).
   -> Row wrap occurs correctly with no overflow-induced extra samples.
